// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset datapath:
// opcode/funct constants, 4-bit ALU control encodings, the main-decoder
// control bundle, and the ALU-control decode helper.
package cpu_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control. ALU_ZERO drives a constant 0 result and marks
    // "no operation" (j, NOP, unsupported funct).
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_NOR  = 4'b1100,
        ALU_ZERO = 4'b1111
    } alu_ctrl_e;

    // Main decoder -> ALU control request
    typedef enum logic [2:0] {
        ALUOP_NONE  = 3'd0,
        ALUOP_ADD   = 3'd1,
        ALUOP_SUB   = 3'd2,
        ALUOP_FUNCT = 3'd3,
        ALUOP_AND   = 3'd4,
        ALUOP_OR    = 3'd5,
        ALUOP_SLT   = 3'd6
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;     // 1: write rd, 0: write rt
        logic    alu_src;     // 1: ALU B = extended immediate
        logic    mem_to_reg;  // 1: write-back from data memory
        logic    reg_write;
        logic    mem_write;
        logic    branch;
        logic    jump;
        logic    ext_zero;    // 1: zero-extend immediate, 0: sign-extend
        alu_op_e alu_op;
    } ctrl_t;

    function automatic alu_ctrl_e alu_control(input alu_op_e op, input logic [5:0] funct);
        alu_ctrl_e c;
        c = ALU_ZERO;
        case (op)
            ALUOP_ADD: c = ALU_ADD;
            ALUOP_SUB: c = ALU_SUB;
            ALUOP_AND: c = ALU_AND;
            ALUOP_OR:  c = ALU_OR;
            ALUOP_SLT: c = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  c = ALU_ADD;
                    FN_SUB:  c = ALU_SUB;
                    FN_AND:  c = ALU_AND;
                    FN_OR:   c = ALU_OR;
                    FN_NOR:  c = ALU_NOR;
                    FN_SLT:  c = ALU_SLT;
                    default: c = ALU_ZERO;
                endcase
            end
            default: c = ALU_ZERO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_control_r_type_alu.sv
// 32-bit ALU.
//   i_a, i_b : operands
//   i_ctrl   : operation select (alu_ctrl_e)
//   o_y      : result (wraps, no overflow trap)
//   o_zero   : o_y == 0
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_ctrl_e   i_ctrl,
    output logic [31:0] o_y,
    output logic        o_zero
);

    always_comb begin
        o_y = 32'd0;
        case (i_ctrl)
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_SLT: o_y = {31'd0, ($signed(i_a) < $signed(i_b))};
            ALU_NOR: o_y = ~(i_a | i_b);
            default: o_y = 32'd0;
        endcase
    end

    assign o_zero = (o_y == 32'd0);

endmodule

// File: rtl/cpu_control_r_type_mem.sv
// Storage blocks of the datapath. Array names are fixed because benches
// preload them hierarchically; none of them is cleared by reset.

// Register bank: 32 x 32, two asynchronous read ports, one write port
// on the rising edge. Register 0 reads as 0 and is never written.
//   i_clk, i_we, i_wr_addr, i_wr_data : write port
//   i_rs_addr/o_rs_data, i_rt_addr/o_rt_data : read ports
module cpu_register_bank (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [4:0]  i_rs_addr,
    input  logic [4:0]  i_rt_addr,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data
);

    logic [31:0] registerBank [0:31];

    always_ff @(posedge i_clk) begin
        if (i_we && (i_wr_addr != 5'd0))
            registerBank[i_wr_addr] <= i_wr_data;
    end

    assign o_rs_data = (i_rs_addr == 5'd0) ? 32'd0 : registerBank[i_rs_addr];
    assign o_rt_data = (i_rt_addr == 5'd0) ? 32'd0 : registerBank[i_rt_addr];

endmodule

// Instruction memory: asynchronous word read. The write port exists so
// a loader can be attached; the core itself ties it off.
//   i_raddr/o_inst : fetch port (word index)
//   i_clk, i_we, i_waddr, i_wdata : load port
module cpu_inst_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_inst
);

    logic [31:0] instBank [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (i_we)
            instBank[i_waddr] <= i_wdata;
    end

    assign o_inst = instBank[i_raddr];

endmodule

// Data memory: asynchronous word read, write on the rising edge.
//   i_addr : word index, i_we/i_wdata : store, o_rdata : load data
module cpu_data_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] dataMemory [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (i_we)
            dataMemory[i_addr] <= i_wdata;
    end

    assign o_rdata = dataMemory[i_addr];

endmodule

// File: rtl/cpu_control_r_type.sv
// Single-cycle 32-bit MIPS-subset CPU (add/sub/and/or/nor/slt, addi,
// slti, andi, ori, lw, sw, beq, j). One instruction per clk_CPU edge.
//   clk_CPU   : clock
//   rst_CPU   : synchronous active-high reset (PC -> 0, writes blocked)
//   resultado : ALU result of the instruction at PC, 0 during reset
module cpu_control_r_type
    import cpu_pkg::*;
#(
    parameter int IM_DEPTH = 64,
    parameter int DM_DEPTH = 64
) (
    input  logic        clk_CPU,
    input  logic        rst_CPU,
    output logic [31:0] resultado
);

    localparam int IM_AW   = $clog2(IM_DEPTH);
    localparam int DM_AW   = $clog2(DM_DEPTH);
    localparam int PC_BITS = IM_AW + 2;
    // PC lives inside the instruction memory's byte range and wraps there.
    localparam logic [31:0] PC_MASK = (32'd1 << PC_BITS) - 32'd1;

    logic [31:0] r_pc;

    logic [31:0] w_inst;
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;

    ctrl_t       w_ctrl;
    alu_ctrl_e   w_alu_ctrl;

    logic [31:0] w_rs_data, w_rt_data;
    logic [31:0] w_imm_ext;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_y;
    logic        w_alu_zero;
    logic [31:0] w_dm_rdata;

    logic        w_reg_we, w_mem_we;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;

    logic [31:0] w_pc_plus4, w_pc_branch, w_pc_jump, w_pc_next;

    // ---------------- fetch / field split ----------------
    cpu_inst_mem #(.DEPTH(IM_DEPTH)) IM (
        .i_clk   (clk_CPU),
        .i_we    (1'b0),
        .i_waddr ({IM_AW{1'b0}}),
        .i_wdata (32'd0),
        .i_raddr (r_pc[PC_BITS-1:2]),
        .o_inst  (w_inst)
    );

    assign w_opcode = w_inst[31:26];
    assign w_rs     = w_inst[25:21];
    assign w_rt     = w_inst[20:16];
    assign w_rd     = w_inst[15:11];
    assign w_funct  = w_inst[5:0];
    assign w_imm    = w_inst[15:0];
    assign w_target = w_inst[25:0];

    // ---------------- main decode ----------------
    always_comb begin
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.alu_src    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
        w_ctrl.reg_write  = 1'b0;
        w_ctrl.mem_write  = 1'b0;
        w_ctrl.branch     = 1'b0;
        w_ctrl.jump       = 1'b0;
        w_ctrl.ext_zero   = 1'b0;
        w_ctrl.alu_op     = ALUOP_NONE;
        case (w_opcode)
            OP_RTYPE: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_ADDI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_SLTI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_SLT;
            end
            OP_ANDI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.ext_zero  = 1'b1;
                w_ctrl.alu_op    = ALUOP_AND;
            end
            OP_ORI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.ext_zero  = 1'b1;
                w_ctrl.alu_op    = ALUOP_OR;
            end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALUOP_SUB;
            end
            OP_J: begin
                w_ctrl.jump = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_alu_ctrl = alu_control(w_ctrl.alu_op, w_funct);

    // ---------------- register bank / ALU / data memory ----------------
    // An R-type with an unsupported funct decodes to ALU_ZERO and is a NOP.
    assign w_reg_we  = w_ctrl.reg_write && (w_alu_ctrl != ALU_ZERO) && !rst_CPU;
    assign w_mem_we  = w_ctrl.mem_write && !rst_CPU;
    assign w_wr_addr = w_ctrl.reg_dst ? w_rd : w_rt;
    assign w_wr_data = w_ctrl.mem_to_reg ? w_dm_rdata : w_alu_y;

    cpu_register_bank BR (
        .i_clk     (clk_CPU),
        .i_we      (w_reg_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data)
    );

    assign w_imm_ext = w_ctrl.ext_zero ? {16'd0, w_imm} : {{16{w_imm[15]}}, w_imm};
    assign w_alu_b   = w_ctrl.alu_src ? w_imm_ext : w_rt_data;

    cpu_alu ALU (
        .i_a    (w_rs_data),
        .i_b    (w_alu_b),
        .i_ctrl (w_alu_ctrl),
        .o_y    (w_alu_y),
        .o_zero (w_alu_zero)
    );

    // Low two address bits are dropped: accesses are word-aligned.
    cpu_data_mem #(.DEPTH(DM_DEPTH)) DM (
        .i_clk   (clk_CPU),
        .i_we    (w_mem_we),
        .i_addr  (w_alu_y[DM_AW+1:2]),
        .i_wdata (w_rt_data),
        .o_rdata (w_dm_rdata)
    );

    assign resultado = rst_CPU ? 32'd0 : w_alu_y;

    // ---------------- next PC ----------------
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_pc_branch = w_pc_plus4 + {w_imm_ext[29:0], 2'b00};
    assign w_pc_jump   = {w_pc_plus4[31:28], w_target, 2'b00};

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_ctrl.jump)
            w_pc_next = w_pc_jump;
        else if (w_ctrl.branch && w_alu_zero)
            w_pc_next = w_pc_branch;
        w_pc_next = w_pc_next & PC_MASK;
    end

    always_ff @(posedge clk_CPU) begin
        if (rst_CPU)
            r_pc <= 32'd0;
        else
            r_pc <= w_pc_next;
    end

endmodule

// File: tb/tb_cpu_control_r_type.sv
module tb_cpu_control_r_type;

  logic        clk_CPU;
  logic        rst_CPU;
  logic [31:0] resultado;

  int vectors;
  int miscompares;

  cpu_control_r_type dut (
    .clk_CPU   (clk_CPU),
    .rst_CPU   (rst_CPU),
    .resultado (resultado)
  );

  // ---------------- clock ----------------
  initial clk_CPU = 1'b0;
  always #5 clk_CPU = ~clk_CPU;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk_CPU);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_CPU     = 1'b1;

    for (int i = 0; i < 64; i++) begin
      dut.IM.instBank[i]   <= 32'hFC00_0000;  // opcode 0x3F: NOP
      dut.DM.dataMemory[i] <= 32'd0;
    end
    for (int i = 0; i < 32; i++) dut.BR.registerBank[i] <= 32'd0;

    dut.BR.registerBank[1]  <= 32'd5;
    dut.BR.registerBank[2]  <= 32'd3;
    dut.BR.registerBank[11] <= 32'h0000_AAAA;
    dut.BR.registerBank[13] <= 32'h0000_DEAD;
    dut.DM.dataMemory[2]    <= 32'h0000_1234;
    dut.DM.dataMemory[4]    <= 32'h0000_5555;
    dut.DM.dataMemory[14]   <= 32'h0000_CAFE;

    dut.IM.instBank[0]  <= enc_r(1, 2, 3,  6'h20);          // add  $3,$1,$2
    dut.IM.instBank[1]  <= enc_r(1, 2, 7,  6'h22);          // sub  $7
    dut.IM.instBank[2]  <= enc_r(1, 2, 8,  6'h24);          // and  $8
    dut.IM.instBank[3]  <= enc_r(1, 2, 9,  6'h25);          // or   $9
    dut.IM.instBank[4]  <= enc_r(1, 2, 10, 6'h27);          // nor  $10
    dut.IM.instBank[5]  <= enc_r(1, 2, 11, 6'h2A);          // slt  $11,$1,$2
    dut.IM.instBank[6]  <= enc_r(2, 1, 12, 6'h2A);          // slt  $12,$2,$1
    dut.IM.instBank[7]  <= enc_r(1, 2, 13, 6'h3F);          // bad funct
    dut.IM.instBank[8]  <= enc_i(6'h08, 0, 1, 16'hFFFF);    // addi $1,$0,-1
    dut.IM.instBank[9]  <= enc_r(1, 2, 14, 6'h2A);          // slt  $14,$1,$2
    dut.IM.instBank[10] <= enc_i(6'h08, 0, 0, 16'h0007);    // addi $0,$0,7
    dut.IM.instBank[11] <= enc_i(6'h08, 0, 5, 16'hFFFF);    // addi $5,$0,-1
    dut.IM.instBank[12] <= enc_i(6'h0D, 0, 6, 16'hFFFF);    // ori  $6,$0,0xFFFF
    dut.IM.instBank[13] <= enc_i(6'h0C, 1, 15, 16'h8001);   // andi $15,$1,0x8001
    dut.IM.instBank[14] <= enc_i(6'h0A, 1, 16, 16'h0001);   // slti $16,$1,1
    dut.IM.instBank[15] <= enc_i(6'h23, 0, 4, 16'h0008);    // lw   $4,8($0)
    dut.IM.instBank[16] <= enc_i(6'h2B, 0, 2, 16'h000C);    // sw   $2,12($0)
    dut.IM.instBank[17] <= enc_i(6'h23, 4, 17, 16'h0004);   // lw   $17,4($4)
    dut.IM.instBank[18] <= enc_i(6'h04, 1, 1, 16'h0002);    // beq  $1,$1,+2
    dut.IM.instBank[19] <= enc_i(6'h08, 0, 20, 16'h0001);   // skipped
    dut.IM.instBank[20] <= enc_i(6'h08, 0, 21, 16'h0001);   // skipped
    dut.IM.instBank[21] <= enc_i(6'h04, 1, 2, 16'h0005);    // beq  $1,$2 (not taken)
    dut.IM.instBank[22] <= enc_j(26'd25);                   // j    100
    dut.IM.instBank[23] <= enc_i(6'h08, 0, 22, 16'h0001);   // skipped
    dut.IM.instBank[24] <= enc_i(6'h08, 0, 22, 16'h0001);   // skipped
    dut.IM.instBank[26] <= enc_i(6'h2B, 0, 2, 16'h0010);    // sw   $2,16($0)

    repeat (3) tick();
    check("rst_resultado", resultado, 32'd0);
    check("rst_pc", dut.r_pc, 32'd0);

    rst_CPU = 1'b0;
    #1;
    check("add_res", resultado, 32'd8);
    tick();
    check("add_br3", dut.BR.registerBank[3], 32'd8);
    check("add_pc", dut.r_pc, 32'd4);
    check("sub_res", resultado, 32'd2);
    tick();
    check("sub_br7", dut.BR.registerBank[7], 32'd2);
    check("and_res", resultado, 32'd1);
    tick();
    check("and_br8", dut.BR.registerBank[8], 32'd1);
    check("or_res", resultado, 32'd7);
    tick();
    check("or_br9", dut.BR.registerBank[9], 32'd7);
    check("nor_res", resultado, 32'hFFFF_FFF8);
    tick();
    check("nor_br10", dut.BR.registerBank[10], 32'hFFFF_FFF8);
    check("slt_res0", resultado, 32'd0);
    tick();
    check("slt_br11", dut.BR.registerBank[11], 32'd0);
    check("slt_res1", resultado, 32'd1);
    tick();
    check("slt_br12", dut.BR.registerBank[12], 32'd1);
    check("badfn_res", resultado, 32'd0);
    tick();
    check("badfn_br13", dut.BR.registerBank[13], 32'h0000_DEAD);
    check("badfn_pc", dut.r_pc, 32'd32);
    check("addi_neg_res", resultado, 32'hFFFF_FFFF);
    tick();
    check("addi_br1", dut.BR.registerBank[1], 32'hFFFF_FFFF);
    check("slt_signed_res", resultado, 32'd1);
    tick();
    check("slt_signed_br14", dut.BR.registerBank[14], 32'd1);
    check("addi_r0_res", resultado, 32'd7);
    tick();
    check("addi_r0_br0", dut.BR.registerBank[0], 32'd0);
    tick();
    check("addi_br5", dut.BR.registerBank[5], 32'hFFFF_FFFF);
    check("ori_res", resultado, 32'h0000_FFFF);
    tick();
    check("ori_br6", dut.BR.registerBank[6], 32'h0000_FFFF);
    check("andi_res", resultado, 32'h0000_8001);
    tick();
    check("andi_br15", dut.BR.registerBank[15], 32'h0000_8001);
    check("slti_res", resultado, 32'd1);
    tick();
    check("slti_br16", dut.BR.registerBank[16], 32'd1);
    check("lw_res", resultado, 32'd8);
    tick();
    check("lw_br4", dut.BR.registerBank[4], 32'h0000_1234);
    check("sw_res", resultado, 32'd12);
    tick();
    check("sw_dm3", dut.DM.dataMemory[3], 32'd3);
    check("lw2_res", resultado, 32'h0000_1238);
    tick();
    check("lw2_br17", dut.BR.registerBank[17], 32'h0000_CAFE);
    check("beq_pc", dut.r_pc, 32'd72);
    check("beq_taken_res", resultado, 32'd0);
    tick();
    check("beq_taken_pc", dut.r_pc, 32'd84);
    check("beq_nt_res", resultado, 32'hFFFF_FFFC);
    tick();
    check("beq_skip_br20", dut.BR.registerBank[20], 32'd0);
    check("beq_skip_br21", dut.BR.registerBank[21], 32'd0);
    check("beq_nt_pc", dut.r_pc, 32'd88);
    check("j_res", resultado, 32'd0);
    tick();
    check("j_pc", dut.r_pc, 32'd100);
    check("badop_res", resultado, 32'd0);
    tick();
    check("j_skip_br22", dut.BR.registerBank[22], 32'd0);
    check("badop_pc", dut.r_pc, 32'd104);
    check("sw2_res", resultado, 32'd16);

    // Reset lands on the sw at 104: its store must not happen.
    rst_CPU = 1'b1;
    #1;
    check("midrst_res", resultado, 32'd0);
    tick();
    check("midrst_dm4", dut.DM.dataMemory[4], 32'h0000_5555);
    check("midrst_pc", dut.r_pc, 32'd0);
    rst_CPU = 1'b0;
    #1;
    // Registers survive reset: $1 = -1, $2 = 3.
    check("restart_res", resultado, 32'd2);
    tick();
    check("restart_br3", dut.BR.registerBank[3], 32'd2);
    check("restart_pc", dut.r_pc, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
